forward_select_gen: RTL and testbench
=====================================

# forward_select_gen

Operand-forwarding and load-use hazard controller for the five-stage datapath. Tracks destination registers of the instructions in EX, MEM, WB and one cycle past WB, and produces the registered 2-bit select codes driving the two EX-stage 32-bit 4:1 operand multiplexers. Also generates the one-cycle load-use stall that holds IF/ID and injects a bubble into EX.

## Interface
- REG_W, 5, register-specifier width
- SEL_W, 2, select-code width; fixed to match the 4:1 operand muxes

- Clk  in  1  single clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  REG_W  source specifiers of the ID instruction
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_dst  in  REG_W  destination specifier of the ID instruction
- id_reg_write  in  1  ID instruction writes id_dst
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch/jump redirect; cancels the ID instruction
- selA, selB  out  SEL_W  registered operand selects for the EX instruction
- stall  out  1  combinational; hold PC and IF/ID this cycle

## Operation
- Four tracking slots EX, MEM, WB, WB1, each {dst, we, mr}. A slot with we=0 or dst=0 never matches.
- Select encoding: 00 register-file read, 01 EX/MEM ALU result, 10 MEM/WB write-back data, 11 WB1 hold register (value written the previous cycle).
- Select computed at ID per operand, for where the producer will be when the consumer is in EX; nearest wins:
  - match EX slot -> 01; else match MEM slot -> 10; else match WB slot -> 11; else 00.
  - operand not used (id_uses_x=0) -> 00.
- Load-use hazard: EX slot has mr=1, we=1, dst≠0, and dst matches a used ID source -> hazard.
- stall = hazard & id_valid & ~flush.
- Per cycle, slots shift: WB1<=WB, WB<=MEM, MEM<=EX. EX slot loads:
  - bubble (all zero) if flush, stall or ~id_valid;
  - otherwise {id_dst, id_reg_write, id_mem_read}.
- selA/selB register: 00 when EX receives a bubble, otherwise the computed codes.
- After a stall cycle the load sits in MEM, so the retried ID instruction gets 10 with no further stall.
- flush and hazard together: flush wins, no stall, bubble into EX.

## Timing
- Reset: all slots zero, selA=selB=00, stall=0 (no EX load present) in the cycle after Rst is sampled high. Reset mid-operation discards all tracked producers.
- selA/selB latency: one cycle; valid throughout the cycle the instruction occupies EX.
- stall is same-cycle combinational from ID inputs and EX slot; asserted for exactly one cycle per load-use pair.
- Back-to-back producers of the same register: youngest (nearest stage) wins.
- Both operands same register: selA=selB.
- WB1 is the oldest slot and drops out the following cycle; a producer four or more instructions older is read from the register file (00).

## Structure
- Shared package: select constants SEL_RF=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10, SEL_WB1=2'b11; REG_W; slot record layout {dst, we, mr}.
- Sub-module fwd_stage_slot: one tracking slot with synchronous clear, bubble load and compare output (match = we & dst≠0 & dst==src), instantiated four times.

## Test plan
- add $3 then immediately sub using $3 as rs -> selA=01, selB=00 during sub's EX, stall=0.
- Producer of $5 followed by two independent instructions, then a reader of $5 -> selA=11; one more gap -> 00.
- lw $4 then add reading $4 as rt -> stall=1 for one cycle, EX bubble selA=selB=00, then add in EX with selB=10.
- Writes to $0 in every stage, reader of $0 -> selects 00, stall never asserted, including for lw $0.
- $7 written by instructions in EX and MEM slots simultaneously, reader of $7 -> 01 (nearest wins).
- lw $2 + dependent reader with flush=1 in the same cycle -> stall=0, EX bubble; Rst asserted mid-stream -> next cycle all selects 00, later reader of previously written register gets 00.

Source files
------------

// File: rtl/forward_select_gen_pkg.sv
// Shared types and constants for the operand-forwarding controller:
// select codes, specifier widths, tracking-slot record and select priority.
package forward_select_gen_pkg;

  localparam int REG_W     = 5;
  localparam int SEL_W     = 2;
  localparam int NUM_SLOTS = 4;  // EX, MEM, WB, WB1

  localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b10;
  localparam logic [SEL_W-1:0] SEL_WB1   = 2'b11;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic             we;
    logic             mr;
  } slot_t;

  // Match bit 0 is the EX slot (nearest producer); the first hit wins.
  // A hit only in WB1 falls back to the register file, which already holds it.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic used,
                                               input logic [NUM_SLOTS-1:0] m);
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (used) begin
      casez (m)
        4'b???1: sel = SEL_EXMEM;
        4'b??10: sel = SEL_MEMWB;
        4'b?100: sel = SEL_WB1;
        default: sel = SEL_RF;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/forward_select_gen_if.sv
// ID-stage request / forwarding-select bundle between the decode stage and
// the forwarding controller.
interface forward_select_gen_if
  import forward_select_gen_pkg::*;
  ();

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dst;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic [SEL_W-1:0] selA;
  logic [SEL_W-1:0] selB;
  logic             stall;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dst, id_reg_write, id_mem_read, flush,
    input  selA, selB, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dst, id_reg_write, id_mem_read, flush,
    output selA, selB, stall
  );

endinterface

// File: rtl/forward_select_gen_fwd_stage_slot.sv
// One pipeline tracking slot {dst, we, mr} with synchronous clear, bubble
// load and per-source producer compare.
module fwd_stage_slot
  import forward_select_gen_pkg::*;
(
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             bubble_i,
  input  slot_t            slot_d_i,
  input  logic [REG_W-1:0] src_a_i,
  input  logic [REG_W-1:0] src_b_i,
  output slot_t            slot_q_o,
  output logic             match_a_o,
  output logic             match_b_o
);

  slot_t slot_q;

  always_ff @(posedge clk_i) begin
    if (srst_i || bubble_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d_i;
    end
  end

  // Writes to register zero are never forwarded.
  logic live;
  assign live      = slot_q.we && (slot_q.dst != '0);
  assign match_a_o = live && (slot_q.dst == src_a_i);
  assign match_b_o = live && (slot_q.dst == src_b_i);
  assign slot_q_o  = slot_q;

endmodule

// File: rtl/forward_select_gen.sv
// Operand-forwarding select generator and load-use stall for the five-stage
// datapath; tracks producers in EX, MEM, WB and WB1.
module forward_select_gen
  import forward_select_gen_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rst,
  forward_select_gen_if.slave  bus
);

  slot_t                slot_in [NUM_SLOTS];
  slot_t                slot_q  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] match_a;
  logic [NUM_SLOTS-1:0] match_b;
  logic [NUM_SLOTS-1:0] bubble;

  logic             hazard;
  logic             stall;
  logic             ex_bubble;
  logic [SEL_W-1:0] sel_a_d, sel_a_q;
  logic [SEL_W-1:0] sel_b_d, sel_b_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign slot_in[gi] = '{dst: bus.id_dst, we: bus.id_reg_write, mr: bus.id_mem_read};
        assign bubble[gi]  = ex_bubble;
      end else begin : g_tail
        assign slot_in[gi] = slot_q[gi-1];
        assign bubble[gi]  = 1'b0;
      end

      fwd_stage_slot u_slot (
        .clk_i     (Clk),
        .srst_i    (Rst),
        .bubble_i  (bubble[gi]),
        .slot_d_i  (slot_in[gi]),
        .src_a_i   (bus.id_rs),
        .src_b_i   (bus.id_rt),
        .slot_q_o  (slot_q[gi]),
        .match_a_o (match_a[gi]),
        .match_b_o (match_b[gi])
      );
    end
  endgenerate

  // A load still in EX cannot forward yet; the consumer waits one cycle and
  // then picks the loaded value up from MEM/WB.
  assign hazard    = slot_q[0].mr &&
                     ((bus.id_uses_rs && match_a[0]) || (bus.id_uses_rt && match_b[0]));
  assign stall     = hazard && bus.id_valid && !bus.flush;
  assign ex_bubble = bus.flush || stall || !bus.id_valid;

  always_comb begin
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!ex_bubble) begin
      sel_a_d = fwd_sel(bus.id_uses_rs, match_a);
      sel_b_d = fwd_sel(bus.id_uses_rt, match_b);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign bus.selA  = sel_a_q;
  assign bus.selB  = sel_b_q;
  assign bus.stall = stall;

endmodule

// File: tb/tb_forward_select_gen.sv
// Directed bench for forward_select_gen: forwarding priority, load-use stall,
// register-zero handling, flush and mid-stream reset.
module tb_forward_select_gen;
  import forward_select_gen_pkg::*;

  logic Clk;
  logic Rst;
  int   errors;
  int   checks;

  forward_select_gen_if bus ();

  forward_select_gen dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic we, input logic mr);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_uses_rs   = urs;
    bus.id_uses_rt   = urt;
    bus.id_dst       = dst;
    bus.id_reg_write = we;
    bus.id_mem_read  = mr;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.flush = 1'b0;
    nop();
    cyc();
    checks++;
    if (bus.selA !== 2'b00 || bus.selB !== 2'b00) begin
      errors++;
      $display("FAIL reset_sel: got selA=%b selB=%b expected 00/00", bus.selA, bus.selB);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 0", bus.stall);
    end
    cyc();
    Rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_forward_ex();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3,$1,$2
    cyc();
    set_id(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // sub $6,$3,$1
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL ex_fwd_stall: got %b expected 0", bus.stall);
    end
    cyc();
    checks++;
    if (bus.selA !== 2'b01 || bus.selB !== 2'b00) begin
      errors++;
      $display("FAIL ex_fwd_sel: got selA=%b selB=%b expected 01/00", bus.selA, bus.selB);
    end
    $display("test_forward_ex: selA=%b selB=%b", bus.selA, bus.selB);
  endtask

  // Producer of $5, then 'gaps' independent instructions, then a reader of $5.
  task automatic test_distance(input int gaps, input logic [1:0] exp_sel);
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc();
    for (int i = 0; i < gaps; i++) begin
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      cyc();
    end
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    cyc();
    checks++;
    if (bus.selA !== exp_sel || bus.selB !== exp_sel) begin
      errors++;
      $display("FAIL distance_%0d: got selA=%b selB=%b expected %b/%b",
               gaps, bus.selA, bus.selB, exp_sel, exp_sel);
    end
    $display("test_distance gaps=%0d: selA=%b selB=%b", gaps, bus.selA, bus.selB);
  endtask

  task automatic test_load_use();
    drain();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);  // lw $4,0($1)
    cyc();
    set_id(1'b1, 5'd1, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // add $6,$1,$4
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b expected 1", bus.stall);
    end
    cyc();
    checks++;
    if (bus.selA !== 2'b00 || bus.selB !== 2'b00) begin
      errors++;
      $display("FAIL lu_bubble_sel: got selA=%b selB=%b expected 00/00", bus.selA, bus.selB);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_retry_stall: got %b expected 0", bus.stall);
    end
    cyc();
    checks++;
    if (bus.selA !== 2'b00 || bus.selB !== 2'b10) begin
      errors++;
      $display("FAIL lu_retry_sel: got selA=%b selB=%b expected 00/10", bus.selA, bus.selB);
    end
    $display("test_load_use: selA=%b selB=%b", bus.selA, bus.selB);
  endtask

  task automatic test_reg_zero();
    drain();
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
      cyc();
    end
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw $0
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_stall: got %b expected 0", bus.stall);
    end
    cyc();
    checks++;
    if (bus.selA !== 2'b00 || bus.selB !== 2'b00) begin
      errors++;
      $display("FAIL zero_sel: got selA=%b selB=%b expected 00/00", bus.selA, bus.selB);
    end
    $display("test_reg_zero: selA=%b selB=%b", bus.selA, bus.selB);
  endtask

  task automatic test_nearest();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0);
    cyc();
    checks++;
    if (bus.selA !== 2'b01 || bus.selB !== 2'b01) begin
      errors++;
      $display("FAIL nearest_sel: got selA=%b selB=%b expected 01/01", bus.selA, bus.selB);
    end
    // rs not used: only rt forwards; nearest $7 producer now in MEM.
    set_id(1'b1, 5'd7, 5'd7, 1'b0, 1'b1, 5'd14, 1'b0, 1'b0);
    cyc();
    checks++;
    if (bus.selA !== 2'b00 || bus.selB !== 2'b10) begin
      errors++;
      $display("FAIL unused_rs_sel: got selA=%b selB=%b expected 00/10", bus.selA, bus.selB);
    end
    $display("test_nearest: selA=%b selB=%b", bus.selA, bus.selB);
  endtask

  task automatic test_flush();
    drain();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);  // lw $2
    cyc();
    set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b expected 0", bus.stall);
    end
    cyc();
    bus.flush = 1'b0;
    checks++;
    if (bus.selA !== 2'b00 || bus.selB !== 2'b00) begin
      errors++;
      $display("FAIL flush_bubble: got selA=%b selB=%b expected 00/00", bus.selA, bus.selB);
    end
    set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc();
    checks++;
    if (bus.selA !== 2'b10 || bus.selB !== 2'b00) begin
      errors++;
      $display("FAIL post_flush_sel: got selA=%b selB=%b expected 10/00", bus.selA, bus.selB);
    end
    // Invalid ID slot never stalls even against a load in EX.
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b1);
    cyc();
    set_id(1'b0, 5'd15, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL invalid_stall: got %b expected 0", bus.stall);
    end
    $display("test_flush: selA=%b selB=%b", bus.selA, bus.selB);
  endtask

  task automatic test_reset_mid();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 5'd10, 5'd8, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    nop();
    checks++;
    if (bus.selA !== 2'b00 || bus.selB !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_sel: got selA=%b selB=%b expected 00/00", bus.selA, bus.selB);
    end
    set_id(1'b1, 5'd10, 5'd9, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stall: got %b expected 0", bus.stall);
    end
    cyc();
    checks++;
    if (bus.selA !== 2'b00 || bus.selB !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_reader: got selA=%b selB=%b expected 00/00", bus.selA, bus.selB);
    end
    $display("test_reset_mid: selA=%b selB=%b", bus.selA, bus.selB);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Rst = 1'b1;
    bus.flush = 1'b0;
    test_reset();
    test_forward_ex();
    test_distance(0, 2'b01);
    test_distance(1, 2'b10);
    test_distance(2, 2'b11);
    test_distance(3, 2'b00);
    test_load_use();
    test_reg_zero();
    test_nearest();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
